// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the unified memory port arbiter: decoder DMType codes
// and the arbiter state encoding.
package mem_port_arbiter_pkg;

  localparam logic [2:0] dm_word              = 3'b000;
  localparam logic [2:0] dm_halfword          = 3'b001;
  localparam logic [2:0] dm_halfword_unsigned = 3'b010;
  localparam logic [2:0] dm_byte              = 3'b011;
  localparam logic [2:0] dm_byte_unsigned     = 3'b100;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_IF   = 2'd1,
    ARB_DM   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/dm_lane_align.sv
// Byte-lane handling for data accesses: store strobes/replication, load
// extract with sign/zero extension, and misalignment detection.
module dm_lane_align
  import mem_port_arbiter_pkg::*;
(
  input  logic [2:0]  dm_type,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (off)
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
  end

  assign half_sel = off[1] ? rdata[31:16] : rdata[15:0];

  // Any code the decoder should never emit falls through to word behaviour.
  always_comb begin
    wstrb      = 4'b1111;
    wdata_lane = wdata;
    rdata_ext  = rdata;
    misalign   = (off != 2'b00);
    case (dm_type)
      dm_halfword, dm_halfword_unsigned: begin
        wstrb      = 4'b0011 << off;
        wdata_lane = {2{wdata[15:0]}};
        misalign   = off[0];
        rdata_ext  = (dm_type == dm_halfword) ? {{16{half_sel[15]}}, half_sel}
                                              : {16'h0000, half_sel};
      end
      dm_byte, dm_byte_unsigned: begin
        wstrb      = 4'b0001 << off;
        wdata_lane = {4{wdata[7:0]}};
        misalign   = 1'b0;
        rdata_ext  = (dm_type == dm_byte) ? {{24{byte_sel[7]}}, byte_sel}
                                          : {24'h000000, byte_sel};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single instruction/data memory port between fetch and the
// load/store path, one transaction at a time, with timeout and stall.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int MAX_DM_RUN = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [31:0]       if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [2:0]        dm_type,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic              dm_ack,
  output logic [31:0]       dm_rdata,
  output logic              dm_err,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output logic              stall,
  output arb_state_t        dbg_state
);

  localparam logic [ADDR_W-1:0] word_mask = ~ADDR_W'(3);
  localparam logic [3:0]        run_max   = 4'(MAX_DM_RUN);
  localparam logic [7:0]        tmo_last  = 8'(TIMEOUT - 1);

  arb_state_t  state, state_next;
  logic [3:0]  run_cnt;
  logic [7:0]  tmo_cnt;
  logic [2:0]  lat_type;
  logic [1:0]  lat_off;
  logic        in_idle, grant_if, grant_dm, tmo_hit, done;
  logic [2:0]  sel_type;
  logic [1:0]  sel_off;
  logic [3:0]  lane_wstrb;
  logic [31:0] lane_wdata, lane_rdata;
  logic        misalign;

  assign in_idle  = (state == ARB_IDLE);
  assign grant_dm = in_idle & dm_req & (~if_req | (run_cnt != run_max));
  assign grant_if = in_idle & if_req & ~grant_dm;
  assign tmo_hit  = (tmo_cnt == tmo_last);
  assign done     = ~in_idle & (mem_ready | tmo_hit);
  assign stall    = (if_req & ~if_ack) | (dm_req & ~dm_ack);
  assign dbg_state = state;

  // Live inputs steer the lanes at launch; latched ones extract the load result.
  assign sel_type = (state == ARB_DM) ? lat_type : dm_type;
  assign sel_off  = (state == ARB_DM) ? lat_off  : dm_addr[1:0];

  dm_lane_align u_lane (
    .dm_type    (sel_type),
    .off        (sel_off),
    .wdata      (dm_wdata),
    .rdata      (mem_rdata),
    .wstrb      (lane_wstrb),
    .wdata_lane (lane_wdata),
    .rdata_ext  (lane_rdata),
    .misalign   (misalign)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ARB_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ARB_IDLE: begin
        if (grant_if)                  state_next = ARB_IF;
        else if (grant_dm && !misalign) state_next = ARB_DM;
      end
      ARB_IF, ARB_DM: if (done) state_next = ARB_IDLE;
      default: state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run_cnt <= 4'd0;
      tmo_cnt <= 8'd0;
    end else begin
      if (!if_req || grant_if) run_cnt <= 4'd0;
      else if (grant_dm)       run_cnt <= run_cnt + 4'd1;
      tmo_cnt <= in_idle ? 8'd0 : tmo_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      if_ack    <= 1'b0;
      if_rdata  <= 32'h0;
      dm_ack    <= 1'b0;
      dm_rdata  <= 32'h0;
      dm_err    <= 1'b0;
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wstrb <= 4'b0000;
      mem_wdata <= 32'h0;
      lat_type  <= dm_word;
      lat_off   <= 2'b00;
    end else begin
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      dm_err <= 1'b0;
      if (grant_if) begin
        mem_valid <= 1'b1;
        mem_we    <= 1'b0;
        mem_addr  <= if_addr & word_mask;
        mem_wstrb <= 4'b0000;
        mem_wdata <= 32'h0;
      end else if (grant_dm) begin
        lat_type <= dm_type;
        lat_off  <= dm_addr[1:0];
        if (misalign) begin
          dm_ack   <= 1'b1;
          dm_err   <= 1'b1;
          dm_rdata <= 32'h0;
        end else begin
          mem_valid <= 1'b1;
          mem_we    <= dm_we;
          mem_addr  <= dm_addr & word_mask;
          mem_wstrb <= dm_we ? lane_wstrb : 4'b0000;
          mem_wdata <= dm_we ? lane_wdata : 32'h0;
        end
      end else if (done) begin
        mem_valid <= 1'b0;
        mem_we    <= 1'b0;
        mem_addr  <= '0;
        mem_wstrb <= 4'b0000;
        mem_wdata <= 32'h0;
        if (state == ARB_IF) begin
          if_ack   <= 1'b1;
          if_rdata <= mem_ready ? mem_rdata : 32'h0;
        end else begin
          dm_ack   <= 1'b1;
          dm_err   <= ~mem_ready;
          dm_rdata <= (mem_ready && !mem_we) ? lane_rdata : 32'h0;
        end
      end
    end
  end

endmodule
